instr_dispatch: RTL

- Instruction fetch/dispatch sequencer for the microcontroller; the initiator side of the executor handshake.
- Owns the PC and reads the synchronous instruction ROM.
- Presents each instruction word on fullBitNum to the opcode executor FSMs (ALU, ALUI, load/store, ...), then waits for their PC_inc/done strobes.
- Between instructions it drives a NOP word for one cycle, which returns every executor to its idle state.

---
 rtl/instr_dispatch_if.sv | 46 ++++
 rtl/instr_dispatch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/instr_dispatch_if.sv
// ---------------------------------------------------------------------------
// instr_dispatch_if
// Bundle between the fetch/dispatch sequencer and its surroundings: the
// synchronous instruction ROM and the opcode executor FSMs.
//
// Signals
//   imem_addr   : ROM address (equals the sequencer's pc)
//   imem_rdata  : ROM data, valid one clock after imem_addr
//   fullBitNum  : instruction word broadcast to the executors (0 = NOP)
//   exec_active : high while an instruction is being executed
//   PC_inc      : executor pulse, advance pc by one
//   pc_load     : executor pulse, load pc from pc_load_val (wins over PC_inc)
//   pc_load_val : branch target
//   done        : OR of all executor done pulses
//
// Handshake: the sequencer "offers" an instruction by holding a non-zero
// fullBitNum with exec_active=1; that offer stays stable until the cycle in
// which done=1 is sampled, which retires the instruction. PC_inc/pc_load/done
// only carry meaning while exec_active=1 and are ignored at any other time.
//
// Modports
//   master : the sequencer side (instr_dispatch)
//   slave  : the ROM/executor side
// ---------------------------------------------------------------------------
interface instr_dispatch_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic [15:0]       fullBitNum;
  logic              exec_active;
  logic              PC_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              done;

  modport master (
    output imem_addr, fullBitNum, exec_active,
    input  imem_rdata, PC_inc, pc_load, pc_load_val, done
  );

  modport slave (
    input  imem_addr, fullBitNum, exec_active,
    output imem_rdata, PC_inc, pc_load, pc_load_val, done
  );
endinterface

// File: rtl/instr_dispatch.sv
// ---------------------------------------------------------------------------
// instr_dispatch
// Instruction fetch/dispatch sequencer. Owns the pc, reads the synchronous
// instruction ROM, broadcasts each instruction on fullBitNum to the opcode
// executors, waits for their done strobe, then drives one NOP cycle so every
// executor falls back to idle before the next instruction.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   run          : level, permits fetching new instructions
//   bus          : instr_dispatch_if.master (ROM + executor signals)
//   halted       : sticky, the halt opcode was reached
//   timeout_err  : sticky, an executor never returned done
//   instr_count  : retired-instruction counter (wraps)
//   state_dbg    : current FSM state encoding
// ---------------------------------------------------------------------------
module instr_dispatch #(
  parameter int         ADDR_W  = 8,
  parameter int         TIMEOUT = 32,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  instr_dispatch_if.master       bus,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [15:0]            instr_count,
  output logic [2:0]             state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_CLEAR = 3'd4,
    S_HALT  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [15:0]       count_next;
  logic [15:0]       fbn, fbn_next;
  logic [TW-1:0]     timer, timer_next;
  logic [3:0]        opcode;

  assign opcode = bus.imem_rdata[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      fbn         <= '0;
      timer       <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_count <= count_next;
      fbn         <= fbn_next;
      timer       <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = instr_count;
    timer_next = timer;
    // fullBitNum is zero everywhere except while an instruction is in EXEC.
    fbn_next   = '0;

    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end

      // ROM samples imem_addr=pc on the edge leaving FETCH; data is valid in LOAD.
      S_FETCH: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        if (opcode == 4'h0) begin
          // NOP retires locally without bothering the executors.
          pc_next    = pc + ADDR_W'(1);
          count_next = instr_count + 16'd1;
          state_next = run ? S_FETCH : S_IDLE;
        end else if (opcode == HALT_OP) begin
          state_next = S_HALT;
        end else begin
          fbn_next   = bus.imem_rdata;
          timer_next = '0;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        fbn_next   = fbn;
        timer_next = timer + TW'(1);
        if (bus.pc_load)     pc_next = bus.pc_load_val;
        else if (bus.PC_inc) pc_next = pc + ADDR_W'(1);
        // done wins over the timeout check, so done in the last allowed
        // cycle still retires the instruction.
        if (bus.done) begin
          count_next = instr_count + 16'd1;
          fbn_next   = '0;
          state_next = S_CLEAR;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          fbn_next   = '0;
          state_next = S_ERROR;
        end
      end

      S_CLEAR: begin
        state_next = run ? S_FETCH : S_IDLE;
      end

      S_HALT:  state_next = S_HALT;
      S_ERROR: state_next = S_ERROR;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.fullBitNum  = fbn;
  assign bus.exec_active = (state == S_EXEC);
  assign halted          = (state == S_HALT);
  assign timeout_err     = (state == S_ERROR);
  assign state_dbg       = state;

endmodule
